dmem_loader: RTL and testbench

Front-panel loader that writes 32-bit words into the KGPminiRISC data memory from an 8-bit switch bank and two push buttons. It holds the processor in reset while loading and releases it when loading ends. It drives the data memory write port, which is the write-side counterpart of the existing button-stepped memory read-out. Bytes arrive least-significant first; every four bytes form one word, written to consecutive addresses starting at 0.

---
 rtl/dmem_loader_pkg.sv | 34 +++
 rtl/dmem_loader_if.sv | 15 +
 rtl/dmem_loader_btn_debounce.sv | 62 ++++++
 rtl/dmem_loader.sv | 135 +++++++++++++
 tb/tb_dmem_loader.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_loader_pkg.sv
// Shared definitions for the front-panel data memory loader.
package dmem_loader_pkg;

    // Loader FSM states. LOAD collects bytes, WRITE/FLUSH own the memory
    // write cycle, RUN releases the processor.
    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FLUSH = 2'd2,
        ST_RUN   = 2'd3
    } state_e;

    // 10 ms of stability at 100 MHz.
    localparam int DEBOUNCE_CYCLES_DEF = 1000000;

    // Bytes that make up one data memory word.
    localparam int BYTES_PER_WORD = 4;

    // Returns w with byte lane idx replaced by b (lane 0 = bits 7:0).
    function automatic logic [31:0] set_lane(input logic [31:0] w,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  b);
        logic [31:0] r;
        r = w;
        case (idx)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_loader_if.sv
// Data memory write port driven by the loader.
//
// Write-only port with no backpressure: mem_we is a one-cycle strobe and
// mem_addr/mem_din are valid in every cycle mem_we is high. The memory must
// accept the write in that cycle (there is no ready).
interface dmem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;

    modport master (output mem_we, output mem_addr, output mem_din);
    modport slave  (input  mem_we, input  mem_addr, input  mem_din);
endinterface

// File: rtl/dmem_loader_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// one-cycle pulse on an accepted 0->1 transition. Releases and bounces that
// do not hold for DEBOUNCE_CYCLES produce no pulse.
module btn_debounce
    import dmem_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;

    // Synchronize, then accept the new level once it has differed from the
    // accepted level for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        pulse_d  = 1'b0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
            pulse_d  = sync2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Conditioner registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
        end
    end

    assign press_pulse = pulse_q;

endmodule

// File: rtl/dmem_loader.sv
// Front-panel loader: assembles bytes from the switch bank into 32-bit words
// (least-significant byte first), writes them to consecutive data memory
// addresses from 0, and holds the processor in reset until loading ends.
module dmem_loader
    import dmem_loader_pkg::*;
#(
    parameter int ADDR_W          = 10,
    parameter int MEM_DEPTH       = 1024,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_strobe,
    input  logic              btn_done,
    input  logic [7:0]        sw,
    dmem_loader_if.master     mem,
    output logic              cpu_rst_hold,
    output logic [ADDR_W:0]   word_count,
    output logic              loading,
    output state_e            dbg_state
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    logic strobe_p;
    logic done_p;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbn_strobe (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_strobe),
        .press_pulse (strobe_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbn_done (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_done),
        .press_pulse (done_p)
    );

    state_e            state_q, state_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              done_pend_q, done_pend_d;

    // Next-state logic: byte capture in LOAD, one write cycle in WRITE/FLUSH,
    // nothing but reset leaves RUN.
    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        addr_d      = addr_q;
        count_d     = count_q;
        done_pend_d = done_pend_q;

        case (state_q)
            ST_LOAD: begin
                // The strobe byte lands first; the done rule then looks at
                // the resulting lane count.
                if (strobe_p) begin
                    word_d     = set_lane(word_q, byte_idx_q, sw);
                    byte_idx_d = byte_idx_q + 1'b1;
                end
                if (strobe_p && (byte_idx_q == 2'd3)) begin
                    state_d     = ST_WRITE;
                    done_pend_d = done_p;
                end else if (done_p) begin
                    state_d     = (byte_idx_d != 2'd0) ? ST_FLUSH : ST_RUN;
                    done_pend_d = 1'b0;
                end
            end

            ST_WRITE, ST_FLUSH: begin
                // The write itself happens this cycle; bookkeeping lands on
                // the following edge. The address saturates at the last word.
                word_d      = '0;
                byte_idx_d  = '0;
                count_d     = count_q + 1'b1;
                done_pend_d = 1'b0;
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end else begin
                    addr_d = addr_q + 1'b1;
                    if ((state_q == ST_FLUSH) || done_pend_q || done_p) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end

            ST_RUN: begin
                state_d = ST_RUN;
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // Loader state registers; reset re-enters LOAD and drops any partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            byte_idx_q  <= '0;
            word_q      <= '0;
            addr_q      <= '0;
            count_q     <= '0;
            done_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            done_pend_q <= done_pend_d;
        end
    end

    // mem_we decodes straight from the state register so that an
    // asynchronous reset removes it immediately.
    assign mem.mem_we   = (state_q == ST_WRITE) || (state_q == ST_FLUSH);
    assign mem.mem_addr = addr_q;
    assign mem.mem_din  = word_q;

    assign loading      = (state_q != ST_RUN);
    assign cpu_rst_hold = loading;
    assign word_count   = count_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_dmem_loader.sv
// Bench for dmem_loader: two instances share stimulus, one with a full-size
// memory and one with a four-word memory, each checked against a byte-level
// reference model.
module tb_dmem_loader;
  import dmem_loader_pkg::*;

  localparam int DC          = 4;
  localparam int DEPTH_BIG   = 1024;
  localparam int DEPTH_SMALL = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_strobe = 1'b0;
  logic btn_done = 1'b0;
  logic [7:0] sw = 8'h00;

  always #5 clk = ~clk;

  dmem_loader_if #(.ADDR_W(10)) if_big ();
  dmem_loader_if #(.ADDR_W(10)) if_small ();

  logic [10:0] wc_big, wc_small;
  logic        hold_big, hold_small, load_big, load_small;
  state_e      st_big, st_small;

  dmem_loader #(.ADDR_W(10), .MEM_DEPTH(DEPTH_BIG), .DEBOUNCE_CYCLES(DC)) dut_big (
    .clk(clk), .rst(rst), .btn_strobe(btn_strobe), .btn_done(btn_done), .sw(sw),
    .mem(if_big), .cpu_rst_hold(hold_big), .word_count(wc_big),
    .loading(load_big), .dbg_state(st_big)
  );

  dmem_loader #(.ADDR_W(10), .MEM_DEPTH(DEPTH_SMALL), .DEBOUNCE_CYCLES(DC)) dut_small (
    .clk(clk), .rst(rst), .btn_strobe(btn_strobe), .btn_done(btn_done), .sw(sw),
    .mem(if_small), .cpu_rst_hold(hold_small), .word_count(wc_small),
    .loading(load_small), .dbg_state(st_small)
  );

  logic        we [2];
  logic [9:0]  addr [2];
  logic [31:0] din [2];
  logic [10:0] wc [2];
  logic        hold [2];
  logic        load [2];
  state_e      st [2];

  assign we[0] = if_big.mem_we;     assign we[1] = if_small.mem_we;
  assign addr[0] = if_big.mem_addr; assign addr[1] = if_small.mem_addr;
  assign din[0] = if_big.mem_din;   assign din[1] = if_small.mem_din;
  assign wc[0] = wc_big;            assign wc[1] = wc_small;
  assign hold[0] = hold_big;        assign hold[1] = hold_small;
  assign load[0] = load_big;        assign load[1] = load_small;
  assign st[0] = st_big;            assign st[1] = st_small;

  int n_pass = 0;
  int n_total = 0;

  // ---------------- reference model ----------------
  logic [41:0] exp_q0[$];
  logic [41:0] exp_q1[$];
  int          m_nb [2];
  logic [31:0] m_word [2];
  int          m_addr [2];
  int          m_cnt [2];
  bit          m_run [2];

  function automatic int depth_of(input int k);
    return (k == 0) ? DEPTH_BIG : DEPTH_SMALL;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_nb[k] = 0; m_word[k] = '0; m_addr[k] = 0; m_cnt[k] = 0; m_run[k] = 1'b0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endfunction

  function automatic void emit_word(input int k);
    logic [41:0] e;
    e = {10'(m_addr[k]), m_word[k]};
    if (k == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
    m_cnt[k]++;
    m_word[k] = '0;
    m_nb[k] = 0;
    if (m_addr[k] == depth_of(k) - 1) m_run[k] = 1'b1;
    else m_addr[k]++;
  endfunction

  function automatic void model_strobe(input logic [7:0] b);
    for (int k = 0; k < 2; k++) begin
      if (!m_run[k]) begin
        m_word[k][8*m_nb[k] +: 8] = b;
        m_nb[k]++;
        if (m_nb[k] == BYTES_PER_WORD) emit_word(k);
      end
    end
  endfunction

  function automatic void model_done();
    for (int k = 0; k < 2; k++) begin
      if (!m_run[k]) begin
        if (m_nb[k] != 0) emit_word(k);
        m_run[k] = 1'b1;
      end
    end
  endfunction

  // ---------------- scoreboard on the write ports ----------------
  always @(negedge clk) begin
    logic [41:0] e;
    if (we[0]) begin
      n_total++;
      if (exp_q0.size() == 0) begin
        $display("FAIL write_big unexpected addr=%0d din=%h required no write", addr[0], din[0]);
      end else begin
        e = exp_q0.pop_front();
        if ({addr[0], din[0]} !== e)
          $display("FAIL write_big addr=%0d din=%h required addr=%0d din=%h", addr[0], din[0], e[41:32], e[31:0]);
        else n_pass++;
      end
    end
    if (we[1]) begin
      n_total++;
      if (exp_q1.size() == 0) begin
        $display("FAIL write_small unexpected addr=%0d din=%h required no write", addr[1], din[1]);
      end else begin
        e = exp_q1.pop_front();
        if ({addr[1], din[1]} !== e)
          $display("FAIL write_small addr=%0d din=%h required addr=%0d din=%h", addr[1], din[1], e[41:32], e[31:0]);
        else n_pass++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; btn_strobe = 1'b0; btn_done = 1'b0; sw = 8'h00;
    repeat (3) @(negedge clk);
    model_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic press(input bit s, input bit d, input logic [7:0] b);
    if (s) model_strobe(b);
    if (d) model_done();
    @(negedge clk);
    sw = b; btn_strobe = s; btn_done = d;
    repeat (DC + 6) @(negedge clk);
    btn_strobe = 1'b0; btn_done = 1'b0;
    repeat (DC + 6) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if ({we[k], addr[k], din[k], wc[k], hold[k], load[k], st[k]} !== {1'b0, 10'd0, 32'd0, 11'd0, 1'b1, 1'b1, ST_LOAD})
        $display("FAIL reset_values dut%0d we=%b addr=%0d din=%h wc=%0d hold=%b load=%b st=%0d required 0/0/0/0/1/1/0",
                 k, we[k], addr[k], din[k], wc[k], hold[k], load[k], st[k]);
      else n_pass++;
    end
  endtask

  task automatic test_one_word();
    do_reset();
    press(1, 0, 8'h11); press(1, 0, 8'h22); press(1, 0, 8'h33); press(1, 0, 8'h44);
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if ({wc[k], load[k], hold[k], addr[k]} !== {11'(m_cnt[k]), !m_run[k], !m_run[k], 10'(m_addr[k])})
        $display("FAIL one_word_state dut%0d wc=%0d load=%b addr=%0d required wc=%0d load=%b addr=%0d",
                 k, wc[k], load[k], addr[k], m_cnt[k], !m_run[k], m_addr[k]);
      else n_pass++;
    end
    n_total++;
    if (exp_q0.size() + exp_q1.size() != 0)
      $display("FAIL one_word_drain pending=%0d required 0", exp_q0.size() + exp_q1.size());
    else n_pass++;
  endtask

  task automatic test_two_words_done();
    do_reset();
    for (int i = 1; i <= 8; i++) press(1, 0, 8'(i));
    press(0, 1, 8'h00);
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if ({wc[k], load[k], hold[k], addr[k]} !== {11'(m_cnt[k]), !m_run[k], !m_run[k], 10'(m_addr[k])})
        $display("FAIL two_words_state dut%0d wc=%0d hold=%b addr=%0d required wc=%0d hold=%b addr=%0d",
                 k, wc[k], hold[k], addr[k], m_cnt[k], !m_run[k], m_addr[k]);
      else n_pass++;
    end
    n_total++;
    if (exp_q0.size() + exp_q1.size() != 0)
      $display("FAIL two_words_drain pending=%0d required 0", exp_q0.size() + exp_q1.size());
    else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    press(1, 0, 8'hAA); press(1, 0, 8'hBB); press(0, 1, 8'h00);
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if ({wc[k], load[k], hold[k], addr[k]} !== {11'(m_cnt[k]), !m_run[k], !m_run[k], 10'(m_addr[k])})
        $display("FAIL flush_state dut%0d wc=%0d load=%b addr=%0d required wc=%0d load=%b addr=%0d",
                 k, wc[k], load[k], addr[k], m_cnt[k], !m_run[k], m_addr[k]);
      else n_pass++;
    end
    n_total++;
    if (exp_q0.size() + exp_q1.size() != 0)
      $display("FAIL flush_drain pending=%0d required 0", exp_q0.size() + exp_q1.size());
    else n_pass++;
  endtask

  task automatic test_bounce();
    do_reset();
    model_strobe(8'h5A);
    @(negedge clk);
    sw = 8'h5A;
    for (int g = 0; g < 3; g++) begin
      btn_strobe = 1'b1; @(negedge clk);
      btn_strobe = 1'b0; repeat (2) @(negedge clk);
    end
    btn_strobe = 1'b1; repeat (DC + 6) @(negedge clk);
    btn_strobe = 1'b0; repeat (DC + 6) @(negedge clk);
    press(1, 0, 8'h6B); press(1, 0, 8'h7C); press(1, 0, 8'h8D);
    press(0, 1, 8'h00);
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if ({wc[k], load[k], hold[k], addr[k]} !== {11'(m_cnt[k]), !m_run[k], !m_run[k], 10'(m_addr[k])})
        $display("FAIL bounce_state dut%0d wc=%0d load=%b addr=%0d required wc=%0d load=%b addr=%0d",
                 k, wc[k], load[k], addr[k], m_cnt[k], !m_run[k], m_addr[k]);
      else n_pass++;
    end
    n_total++;
    if (exp_q0.size() + exp_q1.size() != 0)
      $display("FAIL bounce_drain pending=%0d required 0", exp_q0.size() + exp_q1.size());
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    press(1, 0, 8'hC1); press(1, 0, 8'hC2); press(1, 0, 8'hC3);
    press(1, 1, 8'hC4);
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if ({wc[k], load[k], hold[k], addr[k]} !== {11'(m_cnt[k]), !m_run[k], !m_run[k], 10'(m_addr[k])})
        $display("FAIL simultaneous_state dut%0d wc=%0d load=%b addr=%0d required wc=%0d load=%b addr=%0d",
                 k, wc[k], load[k], addr[k], m_cnt[k], !m_run[k], m_addr[k]);
      else n_pass++;
    end
    n_total++;
    if (exp_q0.size() + exp_q1.size() != 0)
      $display("FAIL simultaneous_drain pending=%0d required 0", exp_q0.size() + exp_q1.size());
    else n_pass++;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 17; i++) press(1, 0, 8'($urandom_range(0, 255)));
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if ({wc[k], load[k], hold[k], addr[k]} !== {11'(m_cnt[k]), !m_run[k], !m_run[k], 10'(m_addr[k])})
        $display("FAIL full_state dut%0d wc=%0d load=%b addr=%0d required wc=%0d load=%b addr=%0d",
                 k, wc[k], load[k], addr[k], m_cnt[k], !m_run[k], m_addr[k]);
      else n_pass++;
    end
    n_total++;
    if (!(addr[1] == 10'd3 || addr[1] == 10'd4))
      $display("FAIL full_no_wrap addr=%0d required 3 or 4", addr[1]);
    else n_pass++;
    press(0, 1, 8'h00);
    n_total++;
    if (exp_q0.size() + exp_q1.size() != 0 || load[0] !== 1'b0)
      $display("FAIL full_drain pending=%0d load_big=%b required 0/0", exp_q0.size() + exp_q1.size(), load[0]);
    else n_pass++;
  endtask

  task automatic test_rst_mid_write();
    bit seen;
    do_reset();
    press(1, 0, 8'h11); press(1, 0, 8'h22); press(1, 0, 8'h33);
    @(negedge clk);
    sw = 8'h44; btn_strobe = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      seen = we[0];
    end
    n_total++;
    if (!seen) $display("FAIL rst_write_timeout mem_we=0 required 1 within 40 cycles");
    else n_pass++;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if ({we[k], addr[k], din[k], wc[k], hold[k], load[k]} !== {1'b0, 10'd0, 32'd0, 11'd0, 1'b1, 1'b1})
        $display("FAIL rst_abort dut%0d we=%b addr=%0d din=%h wc=%0d hold=%b load=%b required 0/0/0/0/1/1",
                 k, we[k], addr[k], din[k], wc[k], hold[k], load[k]);
      else n_pass++;
    end
    btn_strobe = 1'b0;
    repeat (DC + 6) @(negedge clk);
    model_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    press(1, 0, 8'hEF); press(1, 0, 8'hBE); press(1, 0, 8'hAD); press(1, 0, 8'hDE);
    n_total++;
    if (exp_q0.size() + exp_q1.size() != 0 || wc[0] !== 11'd1)
      $display("FAIL reload_deadbeef pending=%0d wc=%0d required 0/1", exp_q0.size() + exp_q1.size(), wc[0]);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int n;
      do_reset();
      n = $urandom_range(1, 20);
      for (int i = 0; i < n - 1; i++) press(1, 0, 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 1) == 1) begin
        press(1, 1, 8'($urandom_range(0, 255)));
      end else begin
        press(1, 0, 8'($urandom_range(0, 255)));
        press(0, 1, 8'h00);
      end
      for (int k = 0; k < 2; k++) begin
        n_total++;
        if ({wc[k], load[k], hold[k], addr[k]} !== {11'(m_cnt[k]), !m_run[k], !m_run[k], 10'(m_addr[k])})
          $display("FAIL random_state run%0d dut%0d wc=%0d load=%b addr=%0d required wc=%0d load=%b addr=%0d",
                   r, k, wc[k], load[k], addr[k], m_cnt[k], !m_run[k], m_addr[k]);
        else n_pass++;
      end
      n_total++;
      if (exp_q0.size() + exp_q1.size() != 0)
        $display("FAIL random_drain run%0d pending=%0d required 0", r, exp_q0.size() + exp_q1.size());
      else n_pass++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    test_reset();
    test_one_word();
    test_two_words_done();
    test_flush();
    test_bounce();
    test_simultaneous();
    test_full();
    test_rst_mid_write();
    test_random();
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
